mem_port_arbiter: RTL and testbench

Shares one single-ported unified memory between the pipeline's instruction-fetch port and its load/store port. Each access runs as a sequenced transaction (issue, fixed-latency wait, response) and the block produces per-port stall signals that freeze the requesting pipeline stage. Data accesses have priority. A starvation counter guarantees forward progress for instruction fetch.

---
 rtl/mem_port_arbiter.sv | 228 ++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported, fixed-latency memory between instruction fetch and load/store.
// Optional performance counters are enabled by defining ARB_PERF_EN.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic [31:0]       dm_rdata,
  output logic              dm_ready,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
`ifdef ARB_PERF_EN
  ,
  output logic [31:0]       perf_if_grants,
  output logic [31:0]       perf_dm_grants,
  output logic [31:0]       perf_conflicts
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  // WAIT spans MEM_LATENCY-1 cycles; the counter runs down to zero.
  localparam logic [3:0] LAT_LOAD   = 4'(MEM_LATENCY - 2);
  localparam logic       OWNER_IF   = 1'b0;
  localparam logic       OWNER_DM   = 1'b1;

  state_t              state_r;
  logic                owner_r;
  logic                txn_we_r;
  logic [3:0]          starve_cnt_r;
  logic [3:0]          lat_cnt_r;
  logic                mem_en_r;
  logic                mem_we_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [31:0]         mem_wdata_r;
  logic                if_ready_r;
  logic                dm_ready_r;

  logic                starve_hit_s;
  logic                grant_if_s;
  logic                grant_dm_s;
  logic                any_req_s;

  assign starve_hit_s = (starve_cnt_r == STARVE_MAX);
  assign any_req_s    = if_req | dm_req;

  // Fixed data priority, overridden once fetch has lost STARVE_LIMIT times in a row.
  always_comb begin
    grant_if_s = 1'b0;
    grant_dm_s = 1'b0;
    if (dm_req && !(if_req && starve_hit_s)) begin
      grant_dm_s = 1'b1;
    end else if (if_req) begin
      grant_if_s = 1'b1;
    end else begin
      grant_if_s = 1'b0;
    end
  end

  // Transaction sequencer: IDLE -> ISSUE -> WAIT* -> RESP -> IDLE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      owner_r      <= OWNER_IF;
      txn_we_r     <= 1'b0;
      starve_cnt_r <= 4'd0;
      lat_cnt_r    <= 4'd0;
      mem_en_r     <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_wdata_r  <= 32'h0;
      if_ready_r   <= 1'b0;
      dm_ready_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if_ready_r <= 1'b0;
          dm_ready_r <= 1'b0;
          if (any_req_s) begin
            state_r  <= ST_ISSUE;
            mem_en_r <= 1'b1;
            if (grant_dm_s) begin
              owner_r     <= OWNER_DM;
              txn_we_r    <= dm_we;
              mem_we_r    <= dm_we;
              mem_addr_r  <= dm_addr;
              mem_wdata_r <= dm_wdata;
              if (if_req && !starve_hit_s) begin
                starve_cnt_r <= starve_cnt_r + 4'd1;
              end else begin
                starve_cnt_r <= starve_cnt_r;
              end
            end else begin
              owner_r      <= OWNER_IF;
              txn_we_r     <= 1'b0;
              mem_we_r     <= 1'b0;
              mem_addr_r   <= if_addr;
              mem_wdata_r  <= 32'h0;
              starve_cnt_r <= 4'd0;
            end
          end else begin
            state_r  <= ST_IDLE;
            mem_en_r <= 1'b0;
            mem_we_r <= 1'b0;
          end
        end
        ST_ISSUE: begin
          mem_en_r <= 1'b0;
          mem_we_r <= 1'b0;
          if (MEM_LATENCY > 1) begin
            state_r   <= ST_WAIT;
            lat_cnt_r <= LAT_LOAD;
          end else begin
            state_r    <= ST_RESP;
            if_ready_r <= (owner_r == OWNER_IF);
            dm_ready_r <= (owner_r == OWNER_DM);
          end
        end
        ST_WAIT: begin
          if (lat_cnt_r == 4'd0) begin
            state_r    <= ST_RESP;
            if_ready_r <= (owner_r == OWNER_IF);
            dm_ready_r <= (owner_r == OWNER_DM);
          end else begin
            lat_cnt_r <= lat_cnt_r - 4'd1;
          end
        end
        ST_RESP: begin
          state_r    <= ST_IDLE;
          if_ready_r <= 1'b0;
          dm_ready_r <= 1'b0;
        end
        default: begin
          state_r    <= ST_IDLE;
          mem_en_r   <= 1'b0;
          mem_we_r   <= 1'b0;
          if_ready_r <= 1'b0;
          dm_ready_r <= 1'b0;
        end
      endcase
    end
  end

  // Read data is only visible to the owner while its ready pulse is high; stores return zero.
  always_comb begin
    if_rdata = 32'h0;
    dm_rdata = 32'h0;
    if (if_ready_r) begin
      if_rdata = mem_rdata;
    end else begin
      if_rdata = 32'h0;
    end
    if (dm_ready_r && !txn_we_r) begin
      dm_rdata = mem_rdata;
    end else begin
      dm_rdata = 32'h0;
    end
  end

  assign if_ready  = if_ready_r;
  assign dm_ready  = dm_ready_r;
  assign if_stall  = if_req & ~if_ready_r;
  assign dm_stall  = dm_req & ~dm_ready_r;
  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;

`ifdef ARB_PERF_EN
  logic [31:0] perf_if_grants_r;
  logic [31:0] perf_dm_grants_r;
  logic [31:0] perf_conflicts_r;
  logic        in_idle_s;

  assign in_idle_s = (state_r == ST_IDLE);

  // Free-running grant and conflict counters, wrapping naturally at 32 bits.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_if_grants_r <= 32'h0;
      perf_dm_grants_r <= 32'h0;
      perf_conflicts_r <= 32'h0;
    end else begin
      if (in_idle_s && grant_if_s) begin
        perf_if_grants_r <= perf_if_grants_r + 32'd1;
      end else begin
        perf_if_grants_r <= perf_if_grants_r;
      end
      if (in_idle_s && grant_dm_s) begin
        perf_dm_grants_r <= perf_dm_grants_r + 32'd1;
      end else begin
        perf_dm_grants_r <= perf_dm_grants_r;
      end
      if (in_idle_s && if_req && dm_req) begin
        perf_conflicts_r <= perf_conflicts_r + 32'd1;
      end else begin
        perf_conflicts_r <= perf_conflicts_r;
      end
    end
  end

  assign perf_if_grants = perf_if_grants_r;
  assign perf_dm_grants = perf_dm_grants_r;
  assign perf_conflicts = perf_conflicts_r;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small fixed-latency (2-cycle) memory model.
module tb_mem_port_arbiter;

  logic        clock;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        if_stall;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        dm_stall;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
`ifdef ARB_PERF_EN
  logic [31:0] perf_if_grants;
  logic [31:0] perf_dm_grants;
  logic [31:0] perf_conflicts;
`endif

  int passed;
  int total;

  logic [31:0] mem [0:63];
  logic [31:0] rd_pipe0;
  logic [31:0] rd_pipe1;

  mem_port_arbiter dut (
    .clock     (clock),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .if_stall  (if_stall),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_ready  (dm_ready),
    .dm_stall  (dm_stall),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef ARB_PERF_EN
    ,
    .perf_if_grants (perf_if_grants),
    .perf_dm_grants (perf_dm_grants),
    .perf_conflicts (perf_conflicts)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model: write on strobe, read data appears two cycles after the strobe cycle.
  always @(posedge clock) begin
    if (mem_en && mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    rd_pipe0 <= mem_en ? mem[mem_addr[7:2]] : 32'h0;
    rd_pipe1 <= rd_pipe0;
  end
  assign mem_rdata = rd_pipe1;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    total++; if (mem_en !== 1'b0 || mem_we !== 1'b0) $display("FAIL reset_mem_ctl: en=%0b we=%0b want 0 0", mem_en, mem_we); else passed++;
    total++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) $display("FAIL reset_mem_bus: addr=%h wdata=%h want 0 0", mem_addr, mem_wdata); else passed++;
    total++; if (if_ready !== 1'b0 || dm_ready !== 1'b0 || if_rdata !== 32'h0 || dm_rdata !== 32'h0)
      $display("FAIL reset_resp: if_ready=%0b dm_ready=%0b if_rdata=%h dm_rdata=%h want all 0", if_ready, dm_ready, if_rdata, dm_rdata); else passed++;
    total++; if (dut.starve_cnt_r !== 4'd0) $display("FAIL reset_starve: got %0d want 0", dut.starve_cnt_r); else passed++;
  endtask

  task automatic test_single_fetch();
    if_req = 1'b1; if_addr = 32'h40;
    #1;
    total++; if (if_stall !== 1'b1 || mem_en !== 1'b0) $display("FAIL fetch_c0: stall=%0b en=%0b want 1 0", if_stall, mem_en); else passed++;
    step();
    total++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h40) $display("FAIL fetch_issue: en=%0b we=%0b addr=%h want 1 0 40", mem_en, mem_we, mem_addr); else passed++;
    total++; if (if_stall !== 1'b1) $display("FAIL fetch_stall_c1: got %0b want 1", if_stall); else passed++;
    step();
    total++; if (mem_en !== 1'b0 || if_ready !== 1'b0 || if_stall !== 1'b1 || if_rdata !== 32'h0)
      $display("FAIL fetch_wait: en=%0b ready=%0b stall=%0b rdata=%h want 0 0 1 0", mem_en, if_ready, if_stall, if_rdata); else passed++;
    step();
    total++; if (if_ready !== 1'b1 || if_rdata !== 32'h4D200493) $display("FAIL fetch_resp: ready=%0b rdata=%h want 1 4d200493", if_ready, if_rdata); else passed++;
    total++; if (if_stall !== 1'b0 || mem_addr !== 32'h40) $display("FAIL fetch_resp_hold: stall=%0b addr=%h want 0 40", if_stall, mem_addr); else passed++;
    if_req = 1'b0;
    step();
    total++; if (if_ready !== 1'b0 || if_rdata !== 32'h0) $display("FAIL fetch_after: ready=%0b rdata=%h want 0 0", if_ready, if_rdata); else passed++;
  endtask

  task automatic test_priority();
    if_req = 1'b1; if_addr = 32'h40;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0;
    step();
    total++; if (mem_en !== 1'b1 || mem_addr !== 32'h0) $display("FAIL prio_dm_issue: en=%0b addr=%h want 1 0", mem_en, mem_addr); else passed++;
    total++; if (dut.starve_cnt_r !== 4'd1) $display("FAIL prio_starve1: got %0d want 1", dut.starve_cnt_r); else passed++;
    step();
    step();
    total++; if (dm_ready !== 1'b1 || dm_rdata !== 32'h11112222 || if_ready !== 1'b0 || if_stall !== 1'b1)
      $display("FAIL prio_dm_resp: dm_ready=%0b dm_rdata=%h if_ready=%0b if_stall=%0b want 1 11112222 0 1", dm_ready, dm_rdata, if_ready, if_stall); else passed++;
    dm_req = 1'b0;
    step();
    total++; if (mem_en !== 1'b0 || dm_ready !== 1'b0) $display("FAIL prio_gap: en=%0b dm_ready=%0b want 0 0", mem_en, dm_ready); else passed++;
    step();
    total++; if (mem_en !== 1'b1 || mem_addr !== 32'h40 || dut.starve_cnt_r !== 4'd0)
      $display("FAIL prio_if_issue: en=%0b addr=%h starve=%0d want 1 40 0", mem_en, mem_addr, dut.starve_cnt_r); else passed++;
    step();
    step();
    total++; if (if_ready !== 1'b1 || if_rdata !== 32'h4D200493 || dm_ready !== 1'b0 || dm_rdata !== 32'h0)
      $display("FAIL prio_if_resp: if_ready=%0b if_rdata=%h dm_ready=%0b dm_rdata=%h want 1 4d200493 0 0", if_ready, if_rdata, dm_ready, dm_rdata); else passed++;
    if_req = 1'b0;
    step();
  endtask

  task automatic test_starvation();
    logic        exp_if;
    logic [31:0] exp_addr;
    logic [3:0]  exp_cnt;
    if_req = 1'b1; if_addr = 32'h40;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h8;
    for (int k = 0; k < 6; k++) begin
      exp_if   = (k == 4);
      exp_addr = exp_if ? 32'h40 : 32'h8;
      exp_cnt  = (k < 4) ? 4'(k + 1) : ((k == 4) ? 4'd0 : 4'd1);
      step();
      total++; if (mem_en !== 1'b1 || mem_addr !== exp_addr) $display("FAIL starve_issue%0d: en=%0b addr=%h want 1 %h", k, mem_en, mem_addr, exp_addr); else passed++;
      total++; if (dut.starve_cnt_r !== exp_cnt) $display("FAIL starve_cnt%0d: got %0d want %0d", k, dut.starve_cnt_r, exp_cnt); else passed++;
      step();
      step();
      total++; if (if_ready !== exp_if || dm_ready !== !exp_if) $display("FAIL starve_resp%0d: if_ready=%0b dm_ready=%0b want %0b %0b", k, if_ready, dm_ready, exp_if, !exp_if); else passed++;
      if (k == 5) begin
        if_req = 1'b0;
        dm_req = 1'b0;
      end
      step();
    end
  endtask

  task automatic test_store();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h4; dm_wdata = 32'd10;
    step();
    total++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h4 || mem_wdata !== 32'd10)
      $display("FAIL store_issue: en=%0b we=%0b addr=%h wdata=%h want 1 1 4 a", mem_en, mem_we, mem_addr, mem_wdata); else passed++;
    step();
    total++; if (mem_en !== 1'b0 || mem_we !== 1'b0 || dm_stall !== 1'b1) $display("FAIL store_wait: en=%0b we=%0b stall=%0b want 0 0 1", mem_en, mem_we, dm_stall); else passed++;
    step();
    total++; if (dm_ready !== 1'b1 || dm_rdata !== 32'h0 || mem_wdata !== 32'd10)
      $display("FAIL store_resp: ready=%0b rdata=%h wdata=%h want 1 0 a", dm_ready, dm_rdata, mem_wdata); else passed++;
    dm_req = 1'b0;
    step();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h4; dm_wdata = 32'h0;
    step();
    step();
    step();
    total++; if (dm_ready !== 1'b1 || dm_rdata !== 32'd10) $display("FAIL store_readback: ready=%0b rdata=%h want 1 a", dm_ready, dm_rdata); else passed++;
    dm_req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    if_req = 1'b1; if_addr = 32'h40;
    step();
    step();
    total++; if (mem_addr !== 32'h40) $display("FAIL rstmid_pre: addr=%h want 40", mem_addr); else passed++;
    reset = 1'b0;
    #1;
    total++; if (mem_en !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || if_ready !== 1'b0 || if_rdata !== 32'h0 || dm_ready !== 1'b0)
      $display("FAIL rstmid_outputs: en=%0b addr=%h wdata=%h if_ready=%0b if_rdata=%h dm_ready=%0b want all 0", mem_en, mem_addr, mem_wdata, if_ready, if_rdata, dm_ready); else passed++;
    step();
    reset = 1'b1;
    #1;
    total++; if (mem_en !== 1'b0) $display("FAIL rstmid_release: en=%0b want 0", mem_en); else passed++;
    step();
    total++; if (mem_en !== 1'b1 || mem_addr !== 32'h40) $display("FAIL rstmid_reissue: en=%0b addr=%h want 1 40", mem_en, mem_addr); else passed++;
    step();
    step();
    total++; if (if_ready !== 1'b1 || if_rdata !== 32'h4D200493) $display("FAIL rstmid_resp: ready=%0b rdata=%h want 1 4d200493", if_ready, if_rdata); else passed++;
    if_req = 1'b0;
    step();
  endtask

`ifdef ARB_PERF_EN
  task automatic test_perf();
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    for (int r = 0; r < 3; r++) test_priority();
    total++; if (perf_if_grants !== 32'd3 || perf_dm_grants !== 32'd3 || perf_conflicts !== 32'd3)
      $display("FAIL perf_counts: if=%0d dm=%0d conf=%0d want 3 3 3", perf_if_grants, perf_dm_grants, perf_conflicts); else passed++;
    force dut.perf_dm_grants_r = 32'hFFFF_FFFF;
    #1;
    release dut.perf_dm_grants_r;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0;
    step();
    total++; if (perf_dm_grants !== 32'h0) $display("FAIL perf_wrap: got %h want 0", perf_dm_grants); else passed++;
    step();
    step();
    dm_req = 1'b0;
    step();
  endtask
`endif

  initial begin
    passed = 0;
    total  = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0]    = 32'h11112222;
    mem[1]    = 32'hDEADBEEF;
    mem[2]    = 32'h33334444;
    mem[16]   = 32'h4D200493;
    rd_pipe0  = 32'h0;
    rd_pipe1  = 32'h0;
    reset     = 1'b0;
    if_req    = 1'b0; if_addr = 32'h0;
    dm_req    = 1'b0; dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0;
    step();
    step();
    test_reset();
    reset = 1'b1;
    step();
    test_single_fetch();
    test_priority();
    test_starvation();
    test_store();
    test_reset_mid();
`ifdef ARB_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
